cache_controller: RTL and testbench
===================================

CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 Parameter: SETS, 64, number of sets; index width = log2(SETS).
REQ-003 Parameter: BASE_ADDR, 1024, byte offset subtracted from every address before mapping.
REQ-004 Ports SHALL be:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low.
- address  in  32  byte address from the MEM stage.
- wdata  in  32  store data.
- MEM_R_EN  in  1  load request, held until ready.
- MEM_W_EN  in  1  store request, held until ready.
- rdata  out  32  load data.
- ready  out  1  access complete this cycle; pipeline freezes while low.
- sram_address  out  32  address to SRAM controller.
- sram_wdata  out  32  store data to SRAM controller.
- sram_r_en  out  1  64-bit block read request.
- sram_w_en  out  1  32-bit word write request.
- sram_rdata  in  64  block from SRAM controller; word 0 in [31:0].
- sram_ready  in  1  SRAM controller completion.

Function
REQ-005 Mapping SHALL use a = address - BASE_ADDR: word select a[2], index a[8:3], tag a[18:9].
REQ-006 Storage SHALL be 2-way set-associative, 64-bit block per way, with a valid bit and a 10-bit tag per way and one LRU bit per set.
REQ-007 The FSM SHALL have states IDLE, READ_MISS and WRITE.
REQ-008 When MEM_W_EN=1, the block SHALL treat the access as a store, even if MEM_R_EN=1.
REQ-009 Read hit in IDLE:
- rdata = selected word, combinationally.
- ready=1 in the same cycle.
- LRU bit set to point to the other way at the next edge.
- No SRAM request.
REQ-010 Read miss in IDLE:
- ready=0.
- Move to READ_MISS.
- Drive sram_r_en=1 and sram_address=address until sram_ready.
REQ-011 In READ_MISS with sram_ready=1:
- rdata = selected word of sram_rdata.
- ready=1 in that cycle.
- Next edge: write the block, tag and valid=1 into the victim way, update LRU, return to IDLE.
REQ-012 Victim selection SHALL be: way0 if invalid; else way1 if invalid; else the way named by LRU.
REQ-013 Store policy SHALL be write-through, no write-allocate.
REQ-014 Store sequence:
- IDLE to WRITE.
- Drive sram_w_en=1, sram_address=address, sram_wdata=wdata.
- ready=0 until sram_ready.
- ready=1 in the sram_ready cycle, then return to IDLE.
REQ-015 On a store hit, the block SHALL overwrite the hit word and update LRU on the sram_ready edge; on a store miss, cache contents SHALL be unchanged.
REQ-016 If MEM_R_EN and MEM_W_EN both drop while in READ_MISS or WRITE, the block SHALL return to IDLE next edge without filling and deassert SRAM requests.
REQ-017 When neither enable is set in IDLE:
- ready=1.
- sram_r_en=0, sram_w_en=0.
- No state change.
REQ-018 sram_r_en and sram_w_en SHALL never be 1 in the same cycle.

Reset
REQ-019 When rst=0 at a clock edge, the block SHALL:
- Move to IDLE.
- Clear all valid and LRU bits.
- Abort any in-flight miss or write without updating the cache.
REQ-020 While rst=0, outputs SHALL be: sram_r_en=0, sram_w_en=0, ready=0, rdata=0.

Configuration
REQ-021 Macro CACHE_BYPASS_EN.
REQ-022 When CACHE_BYPASS_EN is defined:
- Every load SHALL be serviced as a miss (REQ-010/011) with no fill.
- Every store as REQ-014.
- No tag/data storage SHALL be instantiated.
REQ-023 When CACHE_BYPASS_EN is undefined, REQ-005..REQ-018 apply.

Verification
REQ-024 Cold load 1024, SRAM returns 64'h0000_0002_0000_0001 -> rdata=1, ready=1 on the sram_ready cycle; reload of 1028 -> hit, rdata=2, ready=1 with no sram_r_en.
REQ-025 Loads 1024, 1536, 2048 (index 0, tags 0,1,2) -> 2048 evicts the way holding 1024; reload of 1536 hits; reload of 1024 misses.
REQ-026 Store 32'hDEAD_BEEF to cached 1024 -> sram_w_en pulse until sram_ready; later load 1024 hits, rdata=32'hDEAD_BEEF. Store to uncached 3000 -> load 3000 still misses.
REQ-027 MEM_R_EN=MEM_W_EN=1 at 1024 -> only sram_w_en asserted.
REQ-028 rst=0 during READ_MISS -> next cycle IDLE, sram_r_en=0; load 1024 afterwards misses.
REQ-029 With CACHE_BYPASS_EN, two loads of 1024 -> two SRAM reads.

Source files
------------

// File: rtl/cache_controller.sv
// cache_controller: 2-way set-associative, write-through, no-write-allocate
// data cache sitting between the MEM stage and an SRAM controller.
// Read misses fetch a 64-bit block; stores go straight to SRAM.
// Optional build macro: CACHE_BYPASS_EN removes all tag/data storage and
// services every load as an uncached SRAM read.
module cache_controller #(
    parameter int SETS      = 64,
    parameter int BASE_ADDR = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    output logic        sram_r_en,
    output logic        sram_w_en,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
);

    localparam int IDX_W   = (SETS > 1) ? $clog2(SETS) : 1;
    localparam int TAG_W   = 10;
    localparam int TAG_LSB = 3 + IDX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_MISS = 2'd1,
        WRITE     = 2'd2
    } state_t;

    state_t state_q;

    // Address decomposition relative to the cacheable window base
    logic [31:0]      a;
    logic             word_sel;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;

    assign a        = address - 32'(BASE_ADDR);
    assign word_sel = a[2];
    assign idx      = a[3 +: IDX_W];
    assign tag      = a[TAG_LSB +: TAG_W];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{a[1:0], a[31:TAG_LSB+TAG_W]};

    // A store wins when both enables are raised together
    logic is_store, is_load, active;
    assign is_store = MEM_W_EN;
    assign is_load  = MEM_R_EN & ~MEM_W_EN;
    assign active   = MEM_R_EN | MEM_W_EN;

    function automatic logic [31:0] pick_word(input logic [63:0] blk, input logic sel);
        return sel ? blk[63:32] : blk[31:0];
    endfunction

    logic        hit;
    logic [31:0] hit_word;

`ifdef CACHE_BYPASS_EN

    assign hit      = 1'b0;
    assign hit_word = '0;

    logic unused_bypass;
    assign unused_bypass = ^{idx, tag};

`else

    logic [63:0]      data0_q [SETS];
    logic [63:0]      data1_q [SETS];
    logic [TAG_W-1:0] tag0_q  [SETS];
    logic [TAG_W-1:0] tag1_q  [SETS];
    logic [SETS-1:0]  val0_q;
    logic [SETS-1:0]  val1_q;
    logic [SETS-1:0]  lru_q;

    logic hit0, hit1, victim;
    logic fill_en, store_hit_en, touch_en;

    assign hit0     = val0_q[idx] && (tag0_q[idx] == tag);
    assign hit1     = val1_q[idx] && (tag1_q[idx] == tag);
    assign hit      = hit0 | hit1;
    assign hit_word = pick_word(hit0 ? data0_q[idx] : data1_q[idx], word_sel);

    // Fill an invalid way first, otherwise the way the LRU bit names
    assign victim = !val0_q[idx] ? 1'b0 : (!val1_q[idx] ? 1'b1 : lru_q[idx]);

    assign fill_en      = rst && (state_q == READ_MISS) && active && sram_ready;
    assign store_hit_en = rst && (state_q == WRITE) && active && sram_ready && hit;
    assign touch_en     = (rst && (state_q == IDLE) && is_load && hit) || store_hit_en;

    // Valid and LRU bookkeeping; cleared by reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            val0_q <= '0;
            val1_q <= '0;
            lru_q  <= '0;
        end else if (fill_en) begin
            if (victim) val1_q[idx] <= 1'b1;
            else        val0_q[idx] <= 1'b1;
            lru_q[idx] <= ~victim;
        end else if (touch_en) begin
            lru_q[idx] <= hit0;
        end
    end

    // Block and tag storage: refill on miss completion, word merge on store hit
    always_ff @(posedge clk) begin
        if (fill_en) begin
            if (victim) begin
                data1_q[idx] <= sram_rdata;
                tag1_q[idx]  <= tag;
            end else begin
                data0_q[idx] <= sram_rdata;
                tag0_q[idx]  <= tag;
            end
        end else if (store_hit_en) begin
            if (hit0) begin
                if (word_sel) data0_q[idx][63:32] <= wdata;
                else          data0_q[idx][31:0]  <= wdata;
            end else begin
                if (word_sel) data1_q[idx][63:32] <= wdata;
                else          data1_q[idx][31:0]  <= wdata;
            end
        end
    end

`endif

    // Access sequencing: idle, waiting on a block read, or waiting on a write
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (is_store)             state_q <= WRITE;
                    else if (is_load && !hit) state_q <= READ_MISS;
                end
                READ_MISS: if (!active || sram_ready) state_q <= IDLE;
                WRITE:     if (!active || sram_ready) state_q <= IDLE;
                default:   state_q <= IDLE;
            endcase
        end
    end

    // Handshake and data outputs; everything held quiet during reset
    always_comb begin
        ready        = 1'b0;
        rdata        = '0;
        sram_r_en    = 1'b0;
        sram_w_en    = 1'b0;
        sram_address = address;
        sram_wdata   = wdata;
        if (rst) begin
            case (state_q)
                IDLE: begin
                    if (is_load) begin
                        if (hit) begin
                            ready = 1'b1;
                            rdata = hit_word;
                        end
                    end else if (!is_store) begin
                        ready = 1'b1;
                    end
                end
                READ_MISS: begin
                    if (active) begin
                        sram_r_en = 1'b1;
                        if (sram_ready) begin
                            ready = 1'b1;
                            rdata = pick_word(sram_rdata, word_sel);
                        end
                    end
                end
                WRITE: begin
                    if (active) begin
                        sram_w_en = 1'b1;
                        ready     = sram_ready;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: table of load/store accesses
// against a behavioural SRAM memory, plus reset and abort sequences.
module tb_cache_controller;

`ifdef CACHE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address, wdata;
    logic        MEM_R_EN, MEM_W_EN;
    logic [31:0] rdata;
    logic        ready;
    logic [31:0] sram_address, sram_wdata;
    logic        sram_r_en, sram_w_en;
    logic [63:0] sram_rdata;
    logic        sram_ready;

    always #5 clk = ~clk;

    cache_controller dut (
        .clk(clk), .rst(rst),
        .address(address), .wdata(wdata),
        .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
        .rdata(rdata), .ready(ready),
        .sram_address(sram_address), .sram_wdata(sram_wdata),
        .sram_r_en(sram_r_en), .sram_w_en(sram_w_en),
        .sram_rdata(sram_rdata), .sram_ready(sram_ready)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_hit;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] gold [int unsigned];
    logic [31:0] exp_q [$];

    function automatic logic [31:0] gold_rd(input logic [31:0] ad);
        if (gold.exists(ad)) return gold[ad];
        return ad ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [63:0] gold_blk(input logic [31:0] ad);
        logic [31:0] b;
        b = ad & ~32'h7;
        return {gold_rd(b + 32'd4), gold_rd(b)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full access: drive, answer SRAM requests after a short latency,
    // compare load data from the scoreboard when ready rises.
    task automatic run_txn(input vec_t v, input string nm);
        logic saw_r, saw_w, both, done, iface_ok, first;
        logic eh;
        int   waited;
        eh = BYPASS ? 1'b0 : v.exp_hit;
        @(negedge clk);
        address = v.addr; wdata = v.wdata;
        MEM_R_EN = v.rd; MEM_W_EN = v.wr; sram_ready = 1'b0;
        if (v.wr) gold[v.addr] = v.wdata;
        else      exp_q.push_back(gold_rd(v.addr));
        saw_r = 0; saw_w = 0; both = 0; done = 0; iface_ok = 1; first = 0; waited = 0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            #1;
            if (sram_r_en) saw_r = 1;
            if (sram_w_en) saw_w = 1;
            if (sram_r_en && sram_w_en) both = 1;
            if ((sram_r_en || sram_w_en) && sram_address !== v.addr) iface_ok = 0;
            if (sram_w_en && sram_wdata !== v.wdata) iface_ok = 0;
            if (ready) begin
                done  = 1;
                first = (cyc == 0);
                if (!v.wr) check({nm, " rdata"}, {32'd0, rdata}, {32'd0, exp_q.pop_front()});
            end else begin
                @(negedge clk);
                if (sram_r_en || sram_w_en) begin
                    waited++;
                    if (waited >= 2) begin
                        sram_ready = 1'b1;
                        sram_rdata = gold_blk(v.addr);
                    end
                end
            end
        end
        if (!done) begin
            n_chk++; n_fail++;
            $display("FAIL %s timeout: ready never rose", nm);
            if (!v.wr && exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
            if (v.wr) check({nm, " store path {r,w}"}, {62'd0, saw_r, saw_w}, 64'd1);
            else      check({nm, " hit {sram_r,ready1st}"}, {62'd0, saw_r, first}, {62'd0, ~eh, eh});
            check({nm, " sram iface"}, {63'd0, iface_ok & ~both}, 64'd1);
        end
        @(negedge clk);
        MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; sram_ready = 1'b0;
        #1;
        check({nm, " idle {ready,r,w}"}, {61'd0, ready, sram_r_en, sram_w_en}, 64'd4);
    endtask

    task automatic wait_rreq(input string nm);
        int n;
        n = 0;
        while (!sram_r_en && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check({nm, " sram_r_en seen"}, {63'd0, sram_r_en}, 64'd1);
    endtask

    vec_t vecs [14];

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 32'd1024, 32'd0,          1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'd1028, 32'd0,          1'b1};
        vecs[2]  = '{1'b1, 1'b0, 32'd1536, 32'd0,          1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'd2048, 32'd0,          1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'd1536, 32'd0,          1'b1};
        vecs[5]  = '{1'b1, 1'b0, 32'd1024, 32'd0,          1'b0};
        vecs[6]  = '{1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF,  1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'd1024, 32'd0,          1'b1};
        vecs[8]  = '{1'b1, 1'b0, 32'd1028, 32'd0,          1'b1};
        vecs[9]  = '{1'b0, 1'b1, 32'd3000, 32'hCAFE_F00D,  1'b0};
        vecs[10] = '{1'b1, 1'b0, 32'd3000, 32'd0,          1'b0};
        vecs[11] = '{1'b1, 1'b1, 32'd1024, 32'h1234_5678,  1'b0};
        vecs[12] = '{1'b1, 1'b0, 32'd1024, 32'd0,          1'b1};
        vecs[13] = '{1'b1, 1'b0, 32'd2052, 32'd0,          1'b0};

        gold[32'd1024] = 32'h0000_0001;
        gold[32'd1028] = 32'h0000_0002;

        rst = 1'b0; address = 32'd1024; wdata = 32'h5555_AAAA;
        MEM_R_EN = 1'b1; MEM_W_EN = 1'b1;
        sram_rdata = 64'hFFFF_FFFF_FFFF_FFFF; sram_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset outputs {ready,r,w}", {61'd0, ready, sram_r_en, sram_w_en}, 64'd0);
        check("reset rdata", {32'd0, rdata}, 64'd0);
        @(negedge clk);
        rst = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; sram_ready = 1'b0;
        #1;
        check("post-reset idle {ready,r,w}", {61'd0, ready, sram_r_en, sram_w_en}, 64'd4);

        for (int i = 0; i < 14; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Abort a read miss by dropping the request: no fill may happen
        @(negedge clk);
        address = 32'd4096; MEM_R_EN = 1'b1; MEM_W_EN = 1'b0;
        wait_rreq("abort");
        @(negedge clk);
        MEM_R_EN = 1'b0;
        #1;
        check("abort req drop", {63'd0, sram_r_en}, 64'd0);
        @(negedge clk); #1;
        check("abort back idle {ready,r}", {62'd0, ready, sram_r_en}, 64'd2);
        run_txn('{1'b1, 1'b0, 32'd4096, 32'd0, 1'b0}, "abort reload");

        // Reset in the middle of a read miss clears the cache
        @(negedge clk);
        address = 32'd5000; MEM_R_EN = 1'b1;
        wait_rreq("rstmiss");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstmiss in reset {ready,r,w}", {61'd0, ready, sram_r_en, sram_w_en}, 64'd0);
        @(negedge clk);
        rst = 1'b1; MEM_R_EN = 1'b0;
        #1;
        check("rstmiss idle {ready,r}", {62'd0, ready, sram_r_en}, 64'd2);
        run_txn('{1'b1, 1'b0, 32'd1024, 32'd0, 1'b0}, "after reset 1024");
        run_txn('{1'b1, 1'b0, 32'd1028, 32'd0, 1'b1}, "after reset 1028");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
